// File: rtl/hazard_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
// Optional forwarding is selected by the HAZARD_FORWARD_EN macro in the top level.
package hazard_pkg;

  // Destination field is sized for the widest supported register address.
  localparam int DST_W = 8;

  localparam int FWD_REGFILE = 0;
  localparam int ZERO_REG    = 0;

  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
    logic             is_load;
  } entry_t;

  // Width of a forwarding select: register file plus one code per tracked stage.
  function automatic int selw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_addr_match.sv
// Single destination/source compare, qualified by entry valid, port use and
// the hard-wired zero register.
module addr_match
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          valid,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src,
  input  logic          used,
  output logic          hit
);

  assign hit = used && valid && (dst == src) && (src != AW'(ZERO_REG));

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and resolves per-operand forwarding
// and decode stall. Define HAZARD_FORWARD_EN for forwarding; otherwise interlock-only.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int NRD        = 2,
  parameter int LOAD_READY = 1,
  localparam int SELW      = selw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic                issue_load,
  input  logic [AW-1:0]       issue_dst,
  input  logic [NRD*AW-1:0]   src_addr,
  input  logic [NRD-1:0]      src_used,
  input  logic                flush,
  output logic                stall,
  output logic [NRD*SELW-1:0] fwd_sel,
  output logic                busy
);

  entry_t           entries_reg [DEPTH];
  entry_t           entry_next;
  logic [NRD-1:0]   stall_vec;
  logic [DEPTH-1:0] valid_vec;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [DEPTH-1:0] hit;

    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_stage
      addr_match #(.AW(AW)) u_match (
        .valid (entries_reg[gj].valid),
        .dst   (entries_reg[gj].dst[AW-1:0]),
        .src   (src_addr[gi*AW +: AW]),
        .used  (src_used[gi]),
        .hit   (hit[gj])
      );
    end

`ifdef HAZARD_FORWARD_EN
    logic            port_stall;
    logic [SELW-1:0] port_fwd;

    // Walk oldest to youngest so the lowest matching index has the final say.
    always_comb begin
      port_stall = 1'b0;
      port_fwd   = SELW'(FWD_REGFILE);
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hit[k]) begin
          if (!entries_reg[k].is_load || k >= LOAD_READY) begin
            port_stall = 1'b0;
            port_fwd   = SELW'(k + 1);
          end else begin
            port_stall = 1'b1;
            port_fwd   = SELW'(FWD_REGFILE);
          end
        end
      end
    end

    assign stall_vec[gi]               = port_stall;
    assign fwd_sel[gi*SELW +: SELW]    = port_fwd;
`else
    assign stall_vec[gi]               = |hit;
    assign fwd_sel[gi*SELW +: SELW]    = SELW'(FWD_REGFILE);
`endif
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign valid_vec[gi] = entries_reg[gi].valid;
  end

  assign stall = |stall_vec;
  assign busy  = |valid_vec;

  // A stalled or non-writing issue enters EX as a bubble.
  always_comb begin
    entry_next         = '0;
    entry_next.valid   = issue_valid && issue_wr && !stall;
    entry_next.dst     = DST_W'(issue_dst);
    entry_next.is_load = issue_load;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries_reg[k] <= '0;
      end
    end else begin
      entries_reg[0] <= entry_next;
      for (int k = 1; k < DEPTH; k++) begin
        entries_reg[k] <= entries_reg[k-1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int AW         = 5;
  localparam int DEPTH      = 3;
  localparam int NRD        = 2;
  localparam int LOAD_READY = 1;
  localparam int SELW       = $clog2(DEPTH + 1);
  localparam int NRAND      = 400;

  typedef struct {
    logic [AW-1:0] dst;
    bit            load;
    int            edge_no;
  } prod_t;

  typedef struct {
    logic              stall;
    logic [NRD*SELW-1:0] fwd;
    logic              busy;
    logic [NRD*AW-1:0] addr;
    logic [NRD-1:0]    used;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                issue_valid = 1'b0;
  logic                issue_wr = 1'b0;
  logic                issue_load = 1'b0;
  logic [AW-1:0]       issue_dst = '0;
  logic [NRD*AW-1:0]   src_addr = '0;
  logic [NRD-1:0]      src_used = '0;
  logic                flush = 1'b0;
  logic                stall;
  logic [NRD*SELW-1:0] fwd_sel;
  logic                busy;

  prod_t prods[$];
  exp_t  exp_q[$];
  int    cyc = 0;
  int    kill_edge = -1;
  logic  exp_stall_now = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  hazard_scoreboard #(
    .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .LOAD_READY(LOAD_READY)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_load(issue_load), .issue_dst(issue_dst), .src_addr(src_addr),
    .src_used(src_used), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: a producer accepted at edge e sits at stage (cyc - e) until it ages out.
  function automatic exp_t model(input logic [NRD*AW-1:0] a, input logic [NRD-1:0] u);
    exp_t r;
    r.stall = 1'b0;
    r.fwd   = '0;
    r.busy  = 1'b0;
    r.addr  = a;
    r.used  = u;
    for (int p = 0; p < NRD; p++) begin
      int best = -1;
      bit best_load = 0;
      logic [AW-1:0] sa = a[p*AW +: AW];
      foreach (prods[i]) begin
        int st = cyc - prods[i].edge_no;
        if (prods[i].edge_no > kill_edge && st < DEPTH) begin
          r.busy = 1'b1;
          if (u[p] && sa != 0 && prods[i].dst == sa && (best < 0 || st < best)) begin
            best = st;
            best_load = prods[i].load;
          end
        end
      end
      if (best >= 0) begin
`ifdef HAZARD_FORWARD_EN
        if (!best_load || best >= LOAD_READY) r.fwd[p*SELW +: SELW] = SELW'(best + 1);
        else r.stall = 1'b1;
`else
        r.stall = 1'b1;
`endif
      end
    end
    return r;
  endfunction

  // One cycle: let the edge commit the previous inputs, then drive new ones.
  task automatic step(input bit iv, input bit iw, input bit il, input int dst,
                      input int a0, input int a1, input bit [1:0] u,
                      input bit fl, input bit r);
    exp_t e;
    @(posedge clk);
    cyc++;
    if (rst || flush) kill_edge = cyc;
    else if (issue_valid && issue_wr && !exp_stall_now)
      prods.push_back('{dst: issue_dst, load: issue_load, edge_no: cyc});
    while (prods.size() > 0 && cyc - prods[0].edge_no >= DEPTH) void'(prods.pop_front());
    #1;
    issue_valid = iv;
    issue_wr    = iw;
    issue_load  = il;
    issue_dst   = AW'(dst);
    src_addr    = {AW'(a1), AW'(a0)};
    src_used    = u;
    flush       = fl;
    rst         = r;
    e = model(src_addr, src_used);
    exp_stall_now = e.stall;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int want);
    if (act != want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        $display("vec %0d src=%h used=%b stall=%b/%b fwd=%h/%h busy=%b/%b", vectors,
                 e.addr, e.used, stall, e.stall, fwd_sel, e.fwd, busy, e.busy);
        check("stall", int'(stall), int'(e.stall));
        check("fwd_sel", int'(fwd_sel), int'(e.fwd));
        check("busy", int'(busy), int'(e.busy));
      end
    end
  end

  initial begin : stimulus
    // Reset, then idle reads of registers 3 and 4.
    step(0, 0, 0, 0, 4, 3, 2'b11, 0, 1);
    step(0, 0, 0, 0, 4, 3, 2'b11, 0, 0);
    step(0, 0, 0, 0, 4, 3, 2'b11, 0, 0);
    // ALU producer of r8 observed through every stage and beyond.
    step(1, 1, 0, 8, 0, 0, 2'b00, 0, 0);
    repeat (4) step(0, 0, 0, 0, 8, 0, 2'b01, 0, 0);
    // Load producer of r9 read on port 1 directly behind it.
    step(1, 1, 1, 9, 0, 0, 2'b00, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 9, 2'b10, 0, 0);
    // Two producers of r5: youngest wins.
    step(1, 1, 0, 5, 0, 0, 2'b00, 0, 0);
    step(1, 1, 0, 5, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 5, 5, 2'b11, 0, 0);
    // Zero register and unused port.
    step(1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
    step(1, 1, 0, 7, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 7, 7, 2'b00, 0, 0);
    // Flush with simultaneous issue, then reset with simultaneous issue.
    step(1, 1, 0, 11, 0, 0, 2'b00, 0, 0);
    step(1, 1, 0, 12, 0, 0, 2'b00, 0, 0);
    step(1, 1, 0, 13, 11, 12, 2'b11, 1, 0);
    step(0, 0, 0, 0, 11, 13, 2'b11, 0, 0);
    step(1, 1, 0, 14, 0, 0, 2'b00, 0, 0);
    step(1, 1, 1, 15, 0, 0, 2'b00, 0, 0);
    step(1, 1, 0, 16, 14, 15, 2'b11, 0, 1);
    step(0, 0, 0, 0, 14, 16, 2'b11, 0, 0);
    // Randomised traffic over a small register set to provoke hazards.
    for (int i = 0; i < NRAND; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
